pc_gen_btb: RTL and testbench

//  Next-generation fetch PC generator for the Tomasulo core.
//  - Holds the fetch PC and presents it to the instruction fetch stage through a valid/ready handshake.
//  - Embeds a parametrised direct-mapped BTB with saturating direction counters.
//  - Redirects fetch on a predicted-taken hit, trained by the branch resolution / commit port.
//  - A flush from misprediction recovery overrides everything.

---
 rtl/pc_gen_btb_if.sv | 30 +++
 rtl/pc_gen_btb.sv | 122 ++++++++++++
 tb/tb_pc_gen_btb.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_btb_if.sv
// Fetch-PC generator bus: redirect, fetch handshake, BTB training and prediction outputs.
interface pc_gen_btb_if #(
  parameter int ADDR_W = 32
);
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              fetch_ready;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  // Environment side: drives redirects, fetch acceptance and training.
  modport master (
    output flush, flush_addr, fetch_ready,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  pc, pc_valid, pred_taken, pred_target
  );

  // PC generator side.
  modport slave (
    input  flush, flush_addr, fetch_ready,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output pc, pc_valid, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_gen_btb.sv
// Fetch PC generator with an embedded direct-mapped BTB and saturating direction counters.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | held in reset or first cycle after it; pc not presented
// ST_RUN  | pc_valid = 1; pc advances on fetch acceptance
module pc_gen_btb #(
  parameter int                ADDR_W    = 32,
  parameter int                BTB_DEPTH = 16,
  parameter int                CNT_W     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic        clk,
  input  logic        rst,
  pc_gen_btb_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic              pc_valid;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
  logic [ADDR_W-1:0]    btb_target [BTB_DEPTH];
  logic [CNT_W-1:0]     btb_cnt    [BTB_DEPTH];

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic              rd_hit, wr_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              unused_upd_lsb;

  // Byte-offset bits of the training PC never participate in lookup.
  assign unused_upd_lsb = ^bus.upd_pc[1:0];

  // State register for the presentation FSM.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and pc_valid decode; leaves ST_IDLE on the first non-reset edge.
  always_comb begin
    state_d  = state_q;
    pc_valid = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  pc_valid = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  // BTB lookup for the current fetch PC; reads the pre-update entry on collisions.
  always_comb begin
    rd_idx      = pc_q[IDX_W+1:2];
    rd_tag      = pc_q[ADDR_W-1:IDX_W+2];
    rd_hit      = pc_valid & btb_valid[rd_idx] & (btb_tag[rd_idx] == rd_tag);
    pred_taken  = rd_hit & btb_cnt[rd_idx][CNT_W-1];
    pred_target = pred_taken ? btb_target[rd_idx] : '0;
  end

  // Next fetch PC: flush, then predicted redirect, then sequential, else hold.
  always_comb begin
    pc_d = pc_q;
    if (bus.flush)                           pc_d = bus.flush_addr;
    else if (pc_valid && bus.fetch_ready)    pc_d = pred_taken ? pred_target : pc_q + ADDR_W'(4);
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // Training lookup and saturating counter step.
  always_comb begin
    wr_idx  = bus.upd_pc[IDX_W+1:2];
    wr_tag  = bus.upd_pc[ADDR_W-1:IDX_W+2];
    wr_hit  = btb_valid[wr_idx] & (btb_tag[wr_idx] == wr_tag);
    cnt_nxt = btb_cnt[wr_idx];
    if (bus.upd_taken) begin
      if (btb_cnt[wr_idx] != CNT_MAX) cnt_nxt = btb_cnt[wr_idx] + CNT_W'(1);
    end else begin
      if (btb_cnt[wr_idx] != '0)      cnt_nxt = btb_cnt[wr_idx] - CNT_W'(1);
    end
  end

  // Valid bits are the only BTB state that needs clearing on reset.
  always_ff @(posedge clk) begin
    if (rst)
      btb_valid <= '0;
    else if (bus.upd_valid && !wr_hit && bus.upd_taken)
      btb_valid[wr_idx] <= 1'b1;
  end

  // Entry payload: train on hits, allocate on taken misses; not-taken misses are dropped.
  always_ff @(posedge clk) begin
    if (!rst && bus.upd_valid) begin
      if (wr_hit) begin
        btb_cnt[wr_idx] <= cnt_nxt;
        if (bus.upd_taken) btb_target[wr_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= bus.upd_target;
        btb_cnt[wr_idx]    <= CNT_WEAK;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_valid    = pc_valid;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed vector table plus randomized run against an array-based reference model.
module tb_pc_gen_btb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_gen_btb_if #(.ADDR_W(32)) bus ();

  pc_gen_btb #(.ADDR_W(32), .BTB_DEPTH(16), .CNT_W(2), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit        rst;
    bit        flush;
    bit [31:0] flush_addr;
    bit        ready;
    bit        upd_valid;
    bit [31:0] upd_pc;
    bit        upd_taken;
    bit [31:0] upd_target;
    bit [31:0] exp_pc;
    bit        exp_valid;
    bit        exp_pt;
    bit [31:0] exp_tgt;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: 16 entries, index = (addr/4) mod 16, tag = addr/64.
  bit          m_valid;
  longint      m_pc;
  bit          mv   [16];
  longint      mtag [16];
  longint      mtgt [16];
  int          mcnt [16];

  function automatic vec_t mk(bit r, bit fl, bit [31:0] fa, bit rdy,
                              bit uv, bit [31:0] up, bit ut, bit [31:0] utg,
                              bit [31:0] epc, bit ev, bit ept, bit [31:0] etg);
    vec_t v;
    v.rst = r; v.flush = fl; v.flush_addr = fa; v.ready = rdy;
    v.upd_valid = uv; v.upd_pc = up; v.upd_taken = ut; v.upd_target = utg;
    v.exp_pc = epc; v.exp_valid = ev; v.exp_pt = ept; v.exp_tgt = etg;
    return v;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_pt();
    int idx = int'((m_pc / 4) % 16);
    return m_valid && mv[idx] && (mtag[idx] == m_pc / 64) && (mcnt[idx] >= 2);
  endfunction

  function automatic longint model_tgt();
    int idx = int'((m_pc / 4) % 16);
    return model_pt() ? mtgt[idx] : 0;
  endfunction

  task automatic model_step(vec_t v);
    bit     pt;
    longint tg;
    int     ui;
    longint ut;
    if (v.rst) begin
      m_pc = 0; m_valid = 0;
      for (int i = 0; i < 16; i++) mv[i] = 0;
      return;
    end
    pt = model_pt();
    tg = model_tgt();
    if (v.upd_valid) begin
      ui = int'((longint'(v.upd_pc) / 4) % 16);
      ut = longint'(v.upd_pc) / 64;
      if (mv[ui] && mtag[ui] == ut) begin
        if (v.upd_taken) begin
          mcnt[ui] = (mcnt[ui] < 3) ? mcnt[ui] + 1 : 3;
          mtgt[ui] = v.upd_target;
        end else begin
          mcnt[ui] = (mcnt[ui] > 0) ? mcnt[ui] - 1 : 0;
        end
      end else if (v.upd_taken) begin
        mv[ui] = 1; mtag[ui] = ut; mtgt[ui] = v.upd_target; mcnt[ui] = 2;
      end
    end
    if (v.flush)                 m_pc = v.flush_addr;
    else if (m_valid && v.ready) m_pc = pt ? tg : (m_pc + 4) % 64'h1_0000_0000;
    m_valid = 1;
  endtask

  task automatic drive(vec_t v);
    rst             = v.rst;
    bus.flush       = v.flush;
    bus.flush_addr  = v.flush_addr;
    bus.fetch_ready = v.ready;
    bus.upd_valid   = v.upd_valid;
    bus.upd_pc      = v.upd_pc;
    bus.upd_taken   = v.upd_taken;
    bus.upd_target  = v.upd_target;
  endtask

  task automatic check_model();
    chk("model_pc",       bus.pc,          m_pc);
    chk("model_pc_valid", bus.pc_valid,    m_valid);
    chk("model_pred_tkn", bus.pred_taken,  model_pt());
    chk("model_pred_tgt", bus.pred_target, model_tgt());
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    // reset / sequential / hold
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,          32'h0,1'b0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,          32'h0,1'b0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,          32'h0,1'b0,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'h0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'h4,1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,          32'h8,1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,          32'h8,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'h8,1,0,0));
    // train 0x8 taken -> 0x40, then fetch 0,4,8,0x40
    tbl.push_back(mk(0,0,0,0, 1,32'h8,1,32'h40, 32'hC,1,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,          32'hC,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'h0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'h4,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'h8,1,1,32'h40));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,          32'h40,1,0,0));
    // counter walk with same-cycle collision (pre-update entry seen)
    tbl.push_back(mk(0,1,32'h8,0, 0,0,0,0,      32'h40,1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h8,0,0,      32'h8,1,1,32'h40));
    tbl.push_back(mk(0,0,0,0, 1,32'h8,0,0,      32'h8,1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h8,1,32'h40, 32'h8,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'h8,1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,          32'hC,1,0,0));
    // alias: 0x48 shares idx with 0x8 but not tag; training concurrent with flush
    tbl.push_back(mk(0,1,32'h48,0, 1,32'h8,1,32'h40, 32'hC,1,0,0));
    tbl.push_back(mk(0,1,32'h8,0, 0,0,0,0,      32'h48,1,0,0));
    // flush beats predicted-taken accept
    tbl.push_back(mk(0,1,32'h100,1, 0,0,0,0,    32'h8,1,1,32'h40));
    tbl.push_back(mk(0,1,32'hFFFFFFFC,0, 0,0,0,0, 32'h100,1,0,0));
    // wrap
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'hFFFFFFFC,1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,          32'h0,1,0,0));
    // mid-run reset clears BTB; flush during the not-yet-valid cycle still loads pc
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,          32'h0,1,0,0));
    tbl.push_back(mk(0,1,32'h8,0, 0,0,0,0,      32'h0,1'b0,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,          32'h8,1,0,0));

    drive(mk(1,0,0,0, 0,0,0,0, 0,0,0,0));
    @(posedge clk);
    model_step(mk(1,0,0,0, 0,0,0,0, 0,0,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_pc", i),       bus.pc,          tbl[i].exp_pc);
      chk($sformatf("v%0d_pc_valid", i), bus.pc_valid,    tbl[i].exp_valid);
      chk($sformatf("v%0d_pred_tkn", i), bus.pred_taken,  tbl[i].exp_pt);
      chk($sformatf("v%0d_pred_tgt", i), bus.pred_target, tbl[i].exp_tgt);
      check_model();
      model_step(tbl[i]);
    end

    // randomized traffic over a small address pool so indexes alias and tags collide
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rv = mk(0,0,0,0, 0,0,0,0, 0,0,0,0);
      rv.rst        = ($urandom_range(0, 299) == 0);
      rv.flush      = ($urandom_range(0, 15) == 0);
      rv.flush_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 | ($urandom_range(0, 3) << 2)
                                                  : ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      rv.ready      = ($urandom_range(0, 9) < 7);
      rv.upd_valid  = $urandom_range(0, 1);
      rv.upd_pc     = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      rv.upd_taken  = ($urandom_range(0, 9) < 6);
      rv.upd_target = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      drive(rv);
      #1;
      check_model();
      model_step(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
